// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit path.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT_ARP,
        GRANT_UDP,
        ABORT,
        DRAIN,
        IFG
    } arb_state_t;

    typedef enum logic {
        SRC_ARP,
        SRC_UDP
    } src_sel_t;

    localparam int ETH_IFG_BYTES       = 12;
    localparam int ARB_TIMEOUT_DEFAULT = 1024;

    // The source that did not win last time; drives round-robin alternation.
    function automatic src_sel_t other_src(input src_sel_t s);
        return (s == SRC_ARP) ? SRC_UDP : SRC_ARP;
    endfunction

endpackage

// File: rtl/eth_stream_mux.sv
// 2:1 AXI-stream style mux toward the MAC with the matching ready demux.
// With pass_en_i low every output is forced to zero so the caller can
// overlay its own idle/abort/drain behaviour.
module eth_stream_mux import eth_pkg::*; #(
    parameter int DATA_WIDTH = 8
) (
    input  src_sel_t              sel_i,
    input  logic                  pass_en_i,
    input  logic [DATA_WIDTH-1:0] arp_tdata_i,
    input  logic                  arp_tvalid_i,
    input  logic                  arp_tlast_i,
    input  logic [DATA_WIDTH-1:0] udp_tdata_i,
    input  logic                  udp_tvalid_i,
    input  logic                  udp_tlast_i,
    input  logic                  mac_tready_i,
    output logic [DATA_WIDTH-1:0] mac_tdata_o,
    output logic                  mac_tvalid_o,
    output logic                  mac_tlast_o,
    output logic                  arp_tready_o,
    output logic                  udp_tready_o
);

    // Forward the selected source and route MAC ready back only to it.
    always_comb begin
        mac_tdata_o  = '0;
        mac_tvalid_o = 1'b0;
        mac_tlast_o  = 1'b0;
        arp_tready_o = 1'b0;
        udp_tready_o = 1'b0;
        if (pass_en_i) begin
            if (sel_i == SRC_ARP) begin
                mac_tdata_o  = arp_tdata_i;
                mac_tvalid_o = arp_tvalid_i;
                mac_tlast_o  = arp_tlast_i;
                arp_tready_o = mac_tready_i;
            end else begin
                mac_tdata_o  = udp_tdata_i;
                mac_tvalid_o = udp_tvalid_i;
                mac_tlast_o  = udp_tlast_i;
                udp_tready_o = mac_tready_i;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-level arbiter sharing the MAC transmit stream between the ARP reply
// source and the UDP transmit source. A grant is held for a whole frame, an
// idle gap follows every frame, and a source that stalls mid-frame gets its
// frame terminated with an abort beat (tlast+tuser) while the rest is drained.
module eth_tx_arbiter import eth_pkg::*; #(
    parameter int DATA_WIDTH     = 8,
    parameter int ARB_MODE       = 0,
    parameter int IFG_CYCLES     = ETH_IFG_BYTES,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic                  sys_clk_in,
    input  logic                  sys_rstn_in,
    input  logic [DATA_WIDTH-1:0] arp_tdata_in,
    input  logic                  arp_tvalid_in,
    output logic                  arp_tready_out,
    input  logic                  arp_tlast_in,
    input  logic [DATA_WIDTH-1:0] udp_tdata_in,
    input  logic                  udp_tvalid_in,
    output logic                  udp_tready_out,
    input  logic                  udp_tlast_in,
    output logic [DATA_WIDTH-1:0] mac_tdata_out,
    output logic                  mac_tvalid_out,
    input  logic                  mac_tready_in,
    output logic                  mac_tlast_out,
    output logic                  mac_tuser_out,
    output logic                  arb_busy_out,
    output logic                  abort_pulse_out
);

    // Counter widths hold the full terminal value; a zero-cycle gap still
    // needs a 1-bit register to keep the declarations legal.
    localparam int STALL_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int IFG_W   = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [STALL_W-1:0] STALL_MAX   = STALL_W'(TIMEOUT_CYCLES);
    localparam logic [IFG_W-1:0]   IFG_LAST    = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [IFG_W-1:0]   IFG_MAX     = IFG_W'(IFG_CYCLES);

    // Where a finished (or drained) frame goes next.
    localparam arb_state_t END_STATE = (IFG_CYCLES > 0) ? IFG : IDLE;

    arb_state_t         state_q, state_d;
    src_sel_t           last_grant_q, last_grant_d;
    src_sel_t           sel_q, sel_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [IFG_W-1:0]   ifg_cnt_q, ifg_cnt_d;
    logic               armed_q, armed_d;
    logic               abort_pulse_q, abort_pulse_d;

    logic                  pass_en;
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] mux_tdata;
    logic                  mux_tvalid;
    logic                  mux_tlast;
    logic                  mux_arp_tready;
    logic                  mux_udp_tready;

    // Winner of an IDLE arbitration round given the two requests.
    function automatic src_sel_t pick_src(input logic arp_req, input logic udp_req,
                                          input src_sel_t last);
        if (arp_req && udp_req) begin
            return (ARB_MODE == 0) ? SRC_ARP : other_src(last);
        end else if (arp_req) begin
            return SRC_ARP;
        end else begin
            return SRC_UDP;
        end
    endfunction

    assign pass_en = (state_q == GRANT_ARP) || (state_q == GRANT_UDP);
    assign g_valid = (sel_q == SRC_ARP) ? arp_tvalid_in : udp_tvalid_in;
    assign g_last  = (sel_q == SRC_ARP) ? arp_tlast_in  : udp_tlast_in;

    eth_stream_mux #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mux (
        .sel_i        (sel_q),
        .pass_en_i    (pass_en),
        .arp_tdata_i  (arp_tdata_in),
        .arp_tvalid_i (arp_tvalid_in),
        .arp_tlast_i  (arp_tlast_in),
        .udp_tdata_i  (udp_tdata_in),
        .udp_tvalid_i (udp_tvalid_in),
        .udp_tlast_i  (udp_tlast_in),
        .mac_tready_i (mac_tready_in),
        .mac_tdata_o  (mux_tdata),
        .mac_tvalid_o (mux_tvalid),
        .mac_tlast_o  (mux_tlast),
        .arp_tready_o (mux_arp_tready),
        .udp_tready_o (mux_udp_tready)
    );

    // Next-state logic: arbitration, frame tracking, stall timeout, gap timing.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        sel_d         = sel_q;
        stall_cnt_d   = stall_cnt_q;
        ifg_cnt_d     = ifg_cnt_q;
        armed_d       = armed_q;
        abort_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arp_tvalid_in || udp_tvalid_in) begin
                    sel_d        = pick_src(arp_tvalid_in, udp_tvalid_in, last_grant_q);
                    last_grant_d = sel_d;
                    state_d      = (sel_d == SRC_ARP) ? GRANT_ARP : GRANT_UDP;
                    stall_cnt_d  = '0;
                    armed_d      = 1'b0;
                end
            end

            GRANT_ARP, GRANT_UDP: begin
                if (g_valid) begin
                    // Any valid beat clears the stall run; a transferred
                    // last beat ends the frame before a timeout can apply.
                    stall_cnt_d = '0;
                    if (mac_tready_in) begin
                        armed_d = 1'b1;
                        if (g_last) begin
                            state_d   = END_STATE;
                            ifg_cnt_d = '0;
                        end
                    end
                end else if (armed_q) begin
                    // Only a frame that has started can be timed out.
                    if (stall_cnt_q >= STALL_LIMIT) begin
                        state_d       = ABORT;
                        abort_pulse_d = 1'b1;
                    end
                    if (stall_cnt_q != STALL_MAX) begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end
            end

            ABORT: begin
                if (mac_tready_in) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (g_valid && g_last) begin
                    state_d   = END_STATE;
                    ifg_cnt_d = '0;
                end
            end

            IFG: begin
                if (ifg_cnt_q >= IFG_LAST) begin
                    state_d = IDLE;
                end
                if (ifg_cnt_q != IFG_MAX) begin
                    ifg_cnt_d = ifg_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output overlay: pass-through in grant, abort beat, drain sink, else zero.
    always_comb begin
        mac_tdata_out  = mux_tdata;
        mac_tvalid_out = mux_tvalid;
        mac_tlast_out  = mux_tlast;
        mac_tuser_out  = 1'b0;
        arp_tready_out = mux_arp_tready;
        udp_tready_out = mux_udp_tready;
        case (state_q)
            ABORT: begin
                mac_tdata_out  = '0;
                mac_tvalid_out = 1'b1;
                mac_tlast_out  = 1'b1;
                mac_tuser_out  = 1'b1;
                arp_tready_out = 1'b0;
                udp_tready_out = 1'b0;
            end
            DRAIN: begin
                if (sel_q == SRC_ARP) begin
                    arp_tready_out = 1'b1;
                end else begin
                    udp_tready_out = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign arb_busy_out    = (state_q != IDLE);
    assign abort_pulse_out = abort_pulse_q;

    // State and counter registers; reset drops any frame in flight silently.
    always_ff @(posedge sys_clk_in or negedge sys_rstn_in) begin
        if (!sys_rstn_in) begin
            state_q       <= IDLE;
            last_grant_q  <= SRC_UDP;
            sel_q         <= SRC_ARP;
            stall_cnt_q   <= '0;
            ifg_cnt_q     <= '0;
            armed_q       <= 1'b0;
            abort_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            sel_q         <= sel_d;
            stall_cnt_q   <= stall_cnt_d;
            ifg_cnt_q     <= ifg_cnt_d;
            armed_q       <= armed_d;
            abort_pulse_q <= abort_pulse_d;
        end
    end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Frame-level arbiter sharing the single MAC transmit stream between the ARP reply source and the UDP transmit source.
- Sits between arp_tx/udp_tx and the MAC TX path in the RGMII clock domain.
- Holds a grant for a whole frame, enforces an inter-frame idle gap, and aborts frames whose source stalls mid-frame.

Parameters:
- DATA_WIDTH, 8, stream data width in bits.
- ARB_MODE, 0, 0 = fixed priority (ARP over UDP); 1 = round-robin on frame boundaries.
- IFG_CYCLES, 12, idle cycles forced after each frame's last beat; 0 = no gap.
- TIMEOUT_CYCLES, 1024, consecutive mid-frame cycles with granted source valid low that trigger an abort.

Ports:
- sys_clk_in  in  1  block clock.
- sys_rstn_in  in  1  asynchronous active-low reset.
- arp_tdata_in  in  DATA_WIDTH  ARP frame byte.
- arp_tvalid_in  in  1  ARP beat valid.
- arp_tready_out  out  1  ARP beat accepted.
- arp_tlast_in  in  1  ARP last beat of frame.
- udp_tdata_in  in  DATA_WIDTH  UDP frame byte.
- udp_tvalid_in  in  1  UDP beat valid.
- udp_tready_out  out  1  UDP beat accepted.
- udp_tlast_in  in  1  UDP last beat of frame.
- mac_tdata_out  out  DATA_WIDTH  byte to MAC.
- mac_tvalid_out  out  1  beat valid to MAC.
- mac_tready_in  in  1  MAC accepts beat.
- mac_tlast_out  out  1  last beat to MAC.
- mac_tuser_out  out  1  abort marker; valid only with mac_tlast_out.
- arb_busy_out  out  1  high in any state except IDLE.
- abort_pulse_out  out  1  one-cycle pulse when a timeout abort is issued.

Behaviour:
- Reset (asynchronous, active-low): state = IDLE, last_grant = UDP, all counters 0, every output 0 (including both tready outputs).
- A beat transfers when valid and ready are both high at a sys_clk_in rising edge.
- States: IDLE, GRANT_ARP, GRANT_UDP, ABORT, DRAIN, IFG.
- IDLE:
  - Samples both tvalid inputs and moves to a grant state on the next edge (1-cycle arbitration latency). All outputs stay 0 while in IDLE.
  - ARB_MODE=0: ARP wins whenever arp_tvalid_in is high.
  - ARB_MODE=1: if both request, grant the source that is not last_grant. If only one requests, grant it.
  - last_grant updates on every grant.
- GRANT_x:
  - Combinational pass-through: mac_tdata/tvalid/tlast_out = x source signals, x_tready_out = mac_tready_in.
  - Other source tready = 0; mac_tuser_out = 0.
  - A transfer with tlast high goes to IFG (or to IDLE if IFG_CYCLES=0).
  - A new grant is never issued mid-frame.
- Timeout:
  - In GRANT_x, stall_cnt increments each cycle with x tvalid low and resets to 0 on x tvalid high.
  - A frame with no beat yet transferred is never timed out; the first beat arms the counter.
  - When stall_cnt reaches TIMEOUT_CYCLES-1, go to ABORT and pulse abort_pulse_out for one cycle.
- ABORT:
  - Drive mac_tvalid_out=1, mac_tlast_out=1, mac_tuser_out=1, mac_tdata_out=0; source tready = 0.
  - Hold until mac_tready_in, then go to DRAIN.
- DRAIN:
  - Granted source tready = 1; mac_tvalid_out = 0; beats are discarded.
  - Leave to IFG/IDLE on a source beat with tlast high.
- IFG:
  - Counter runs IFG_CYCLES cycles with all outputs 0, then go to IDLE.
  - Requests present during IFG are evaluated in IDLE.
- Simultaneous events:
  - A last beat and a timeout in the same cycle: the last beat wins, no abort.
  - Both requests arriving in the same IDLE cycle are resolved per ARB_MODE.
- Counter widths:
  - stall_cnt is $clog2(TIMEOUT_CYCLES+1) bits; ifg_cnt is $clog2(IFG_CYCLES+1) bits.
  - Both saturate; neither wraps.
- Reset mid-frame: the frame is truncated silently (no tuser), and the block restarts in IDLE.

Decomposition:
- Shared package eth_pkg holds:
  - arb_state_t enum (IDLE, GRANT_ARP, GRANT_UDP, ABORT, DRAIN, IFG);
  - src_sel_t enum (SRC_ARP, SRC_UDP);
  - constants ETH_IFG_BYTES=12 and ARB_TIMEOUT_DEFAULT=1024.
- One natural sub-module, eth_stream_mux: the combinational 2:1 data/valid/last mux and ready demux driven by src_sel_t and a pass-enable bit. FSM and counters stay in eth_tx_arbiter.

Test Plan:
- ARB_MODE=0, only UDP sends a 72-byte frame, mac_tready_in=1:
  - mac output matches input byte-for-byte and tlast is on beat 72;
  - mac_tvalid_out rises 1 cycle after udp_tvalid_in;
  - then 12 idle cycles before the next grant.
- ARB_MODE=0, ARP (42 bytes) and UDP (72 bytes) both valid in the same cycle:
  - ARP frame is sent first, UDP frame starts exactly 12+1 cycles after ARP tlast.
- ARB_MODE=1, both sources continuously valid for 4 frames each:
  - grant order is ARP, UDP, ARP, UDP…
- UDP frame stalls after byte 10 for 1024 cycles:
  - one abort beat (tlast=1, tuser=1, data 0x00) and a single abort_pulse_out are produced;
  - the remaining UDP bytes are drained with no mac_tvalid_out;
  - 12 IFG cycles follow.
- mac_tready_in toggling 1/0 every cycle during a 72-byte ARP frame:
  - all 72 bytes arrive in order, no duplicates;
  - udp_tready_out stays 0 throughout.
- sys_rstn_in asserted at byte 30 of a UDP frame:
  - all outputs are 0 immediately (asynchronously);
  - after release, a new ARP request is granted 1 cycle after being sampled in IDLE.
